// File: rtl/serial_load_controller_pkg.sv
// Shared types for the serial grid loader: FSM state encoding and counter sizing.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    RUNNING = 2'd3
  } state_t;

  // Holds 0..data_size+1 so an over-long frame saturates one past a full grid.
  function automatic int bit_cnt_width(input int data_size);
    return $clog2(data_size + 2);
  endfunction

endpackage

// File: rtl/serial_load_controller_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous wire, with a rising-edge pulse
// derived from the synchronized level.
module sync_edge_detect #(
  parameter int sync_stages = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  output logic Q,
  output logic RISE
);

  logic [sync_stages-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus a one-cycle delayed copy of the synced level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[sync_stages-2:0], D};
      prev_r <= sync_r[sync_stages-1];
    end
  end

  assign Q    = sync_r[sync_stages-1];
  assign RISE = Q & ~prev_r;

endmodule

// File: rtl/serial_load_controller.sv
// Receives a serial grid image into system_memory_v2 via LOAD_MODE shifts, checks
// the frame length, then paces generations with periodic RUN_MODE strobes.
module serial_load_controller
  import loader_pkg::*;
#(
  parameter int data_size   = 64,
  parameter int sync_stages = 2,
  parameter int gen_period  = 1000000,
  parameter int gen_width   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SER_CLK,
  input  logic                 SER_DATA,
  input  logic                 SER_FRAME_N,
  input  logic                 RUN_REQ,
  input  logic                 HALT_REQ,
  output logic                 SERIAL_IN,
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 LOADED,
  output logic                 FRAME_ERR,
  output logic [gen_width-1:0] GEN_COUNT,
  output logic [1:0]           STATE
);

  localparam int CW = bit_cnt_width(data_size);
  localparam int PW = (gen_period > 2) ? $clog2(gen_period) : 1;
  localparam logic [CW-1:0] FULL_CNT    = CW'(data_size);
  localparam logic [CW-1:0] SAT_CNT     = CW'(data_size + 1);
  localparam logic [PW-1:0] LAST_PERIOD = PW'(gen_period - 1);

  state_t                 state_r, state_nxt_s;
  logic [sync_stages-1:0] data_sync_r;
  logic [CW-1:0]          bit_cnt_r;
  logic [PW-1:0]          period_cnt_r;
  logic [gen_width-1:0]   gen_count_r;
  logic                   load_mode_r, serial_in_r, run_mode_r, loaded_r, frame_err_r;
  logic                   frame_s, clk_rise_s;
  logic                   frame_rise_unused, clk_level_unused, unused_s;
  logic                   shift_s, tick_s, enter_load_s, load_ok_s, load_bad_s;

  sync_edge_detect #(.sync_stages(sync_stages)) u_clk_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .D    (SER_CLK),
    .Q    (clk_level_unused),
    .RISE (clk_rise_s)
  );

  // Frame is synchronized active-high so the cleared synchronizer reads "no frame".
  sync_edge_detect #(.sync_stages(sync_stages)) u_frame_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .D    (~SER_FRAME_N),
    .Q    (frame_s),
    .RISE (frame_rise_unused)
  );

  assign unused_s = frame_rise_unused ^ clk_level_unused;

  // Data synchronizer, same depth as the clock path so bit and edge stay aligned.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_sync_r <= '0;
    end else begin
      data_sync_r <= {data_sync_r[sync_stages-2:0], SER_DATA};
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; frame start wins over RUN_REQ in READY.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_s) state_nxt_s = LOADING;
        else         state_nxt_s = IDLE;
      end
      LOADING: begin
        if (frame_s)                    state_nxt_s = LOADING;
        else if (bit_cnt_r == FULL_CNT) state_nxt_s = READY;
        else                            state_nxt_s = IDLE;
      end
      READY: begin
        if (frame_s)      state_nxt_s = LOADING;
        else if (RUN_REQ) state_nxt_s = RUNNING;
        else              state_nxt_s = READY;
      end
      RUNNING: begin
        if (HALT_REQ) state_nxt_s = READY;
        else          state_nxt_s = RUNNING;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode feeding the registered outputs and counters.
  always_comb begin
    shift_s      = 1'b0;
    tick_s       = 1'b0;
    enter_load_s = 1'b0;
    load_ok_s    = 1'b0;
    load_bad_s   = 1'b0;
    case (state_r)
      IDLE, READY: begin
        enter_load_s = (state_nxt_s == LOADING);
      end
      LOADING: begin
        shift_s    = frame_s & clk_rise_s;
        load_ok_s  = (state_nxt_s == READY);
        load_bad_s = (state_nxt_s == IDLE);
      end
      RUNNING: begin
        tick_s = ~HALT_REQ & (period_cnt_r == LAST_PERIOD);
      end
      default: begin
        shift_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      load_mode_r  <= 1'b0;
      serial_in_r  <= 1'b0;
      run_mode_r   <= 1'b0;
      loaded_r     <= 1'b0;
      frame_err_r  <= 1'b0;
      bit_cnt_r    <= '0;
      period_cnt_r <= '0;
      gen_count_r  <= '0;
    end else begin
      load_mode_r <= shift_s;
      serial_in_r <= data_sync_r[sync_stages-1];
      run_mode_r  <= tick_s;

      if (enter_load_s)                          bit_cnt_r <= '0;
      else if (shift_s && (bit_cnt_r != SAT_CNT)) bit_cnt_r <= bit_cnt_r + 1'b1;

      if ((state_r == RUNNING) && !HALT_REQ) period_cnt_r <= tick_s ? '0 : period_cnt_r + 1'b1;
      else                                   period_cnt_r <= '0;

      if (enter_load_s) gen_count_r <= '0;
      else if (tick_s)  gen_count_r <= gen_count_r + 1'b1;

      if (enter_load_s)   loaded_r <= 1'b0;
      else if (load_ok_s) loaded_r <= 1'b1;

      if (enter_load_s)    frame_err_r <= 1'b0;
      else if (load_bad_s) frame_err_r <= 1'b1;
    end
  end

  assign SERIAL_IN = serial_in_r;
  assign LOAD_MODE = load_mode_r;
  assign RUN_MODE  = run_mode_r;
  assign LOADED    = loaded_r;
  assign FRAME_ERR = frame_err_r;
  assign GEN_COUNT = gen_count_r;
  assign STATE     = state_r;

endmodule

// File: tb/tb_serial_load_controller.sv
// Scoreboard bench: stimulus queues expected shift bits and generation strobes,
// a negedge monitor pops and compares them as the controller emits them.
module tb_serial_load_controller;
  import loader_pkg::*;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        SER_CLK = 1'b0, SER_DATA = 1'b0, SER_FRAME_N = 1'b1;
  logic        RUN_REQ = 1'b0, HALT_REQ = 1'b0;
  logic        SERIAL_IN, LOAD_MODE, RUN_MODE, LOADED, FRAME_ERR;
  logic [15:0] GEN_COUNT;
  logic [1:0]  STATE;

  typedef struct { logic b; int at; } load_t;
  typedef struct { int at; int gen; } run_t;

  load_t load_q[$];
  run_t  run_q[$];
  int    cyc = 0;
  int    n_vec = 0, n_err = 0;
  int    c0, c1;

  serial_load_controller #(.data_size(8), .sync_stages(2), .gen_period(4), .gen_width(16)) dut (
    .CLK(CLK), .RESET(RESET), .SER_CLK(SER_CLK), .SER_DATA(SER_DATA), .SER_FRAME_N(SER_FRAME_N),
    .RUN_REQ(RUN_REQ), .HALT_REQ(HALT_REQ), .SERIAL_IN(SERIAL_IN), .LOAD_MODE(LOAD_MODE),
    .RUN_MODE(RUN_MODE), .LOADED(LOADED), .FRAME_ERR(FRAME_ERR), .GEN_COUNT(GEN_COUNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 1000 && cyc < t; i++) tick();
  endtask

  task automatic frame_start();
    SER_FRAME_N = 1'b0;
    SER_CLK = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_bit(input logic b, input logic expect_shift);
    load_t e;
    SER_DATA = b;
    repeat (4) tick();
    SER_CLK = 1'b1;
    if (expect_shift) begin
      e.b = b;
      e.at = cyc + 3;
      load_q.push_back(e);
    end
    repeat (4) tick();
    SER_CLK = 1'b0;
  endtask

  task automatic frame_end();
    repeat (4) tick();
    SER_FRAME_N = 1'b1;
    repeat (6) tick();
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    frame_start();
    for (int i = 0; i < n; i++) send_bit(bits[n-1-i], 1'b1);
    frame_end();
  endtask

  task automatic push_run(input int at, input int gen);
    run_t e;
    e.at = at;
    e.gen = gen;
    run_q.push_back(e);
  endtask

  task automatic chk_status(input string tag, input state_t s, input int loaded, input int ferr);
    chk({tag, "_state"}, int'(STATE), int'(s));
    chk({tag, "_loaded"}, int'(LOADED), loaded);
    chk({tag, "_frame_err"}, int'(FRAME_ERR), ferr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_serial_in"}, int'(SERIAL_IN), 0);
    chk({tag, "_load_mode"}, int'(LOAD_MODE), 0);
    chk({tag, "_run_mode"}, int'(RUN_MODE), 0);
    chk({tag, "_gen_count"}, int'(GEN_COUNT), 0);
    chk_status(tag, IDLE, 0, 0);
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge CLK) begin
    load_t le;
    run_t  re;
    if (!RESET) begin
      if (LOAD_MODE) begin
        chk("load_pulse_expected", (load_q.size() > 0) ? 1 : 0, 1);
        if (load_q.size() > 0) begin
          le = load_q.pop_front();
          chk("serial_bit", int'(SERIAL_IN), int'(le.b));
          chk("load_latency_cycle", cyc, le.at);
        end
      end
      if (RUN_MODE) begin
        chk("load_during_run_strobe", int'(LOAD_MODE), 0);
        chk("run_pulse_expected", (run_q.size() > 0) ? 1 : 0, 1);
        if (run_q.size() > 0) begin
          re = run_q.pop_front();
          chk("run_cycle", cyc, re.at);
          chk("gen_count_at_run", int'(GEN_COUNT), re.gen);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk_all_zero("reset");
    RESET = 1'b0;
    repeat (3) tick();

    send_frame(16'h00A5, 8);
    chk_status("good_a5", READY, 1, 0);
    send_frame(16'h0015, 5);
    chk_status("short5", IDLE, 0, 1);
    send_frame(16'h02CB, 10);
    chk_status("long10", IDLE, 0, 1);
    send_frame(16'h00C3, 8);
    chk_status("good_c3", READY, 1, 0);

    // Stepping: strobes 4 cycles apart, halted in the tick cycle of the fourth.
    c0 = cyc;
    RUN_REQ = 1'b1;
    for (int k = 1; k <= 3; k++) push_run(c0 + 1 + 4 * k, k);
    tick();
    RUN_REQ = 1'b0;
    wait_until(c0 + 16);
    HALT_REQ = 1'b1;
    tick();
    HALT_REQ = 1'b0;
    chk_status("halt", READY, 1, 0);
    chk("halt_gen_count", int'(GEN_COUNT), 3);

    // Restart; a frame with a clock edge while running must be ignored.
    c1 = cyc;
    RUN_REQ = 1'b1;
    for (int k = 0; k <= 4; k++) push_run(c1 + 5 + 4 * k, 4 + k);
    tick();
    RUN_REQ = 1'b0;
    frame_start();
    send_bit(1'b1, 1'b0);
    SER_FRAME_N = 1'b1;
    repeat (3) tick();
    chk_status("frame_in_run", RUNNING, 1, 0);
    wait_until(c1 + 24);
    HALT_REQ = 1'b1;
    tick();
    HALT_REQ = 1'b0;
    chk_status("halt2", READY, 1, 0);
    chk("halt2_gen_count", int'(GEN_COUNT), 8);

    // Frame and RUN_REQ reach the FSM together: reload wins.
    SER_FRAME_N = 1'b0;
    SER_CLK = 1'b0;
    repeat (2) tick();
    RUN_REQ = 1'b1;
    tick();
    RUN_REQ = 1'b0;
    chk_status("reload_prio", LOADING, 0, 0);
    chk("reload_gen_count", int'(GEN_COUNT), 0);
    for (int i = 7; i >= 0; i--) send_bit(i[0] ^ i[1], 1'b1);
    frame_end();
    chk_status("reload_done", READY, 1, 0);

    // Reset in the middle of a frame.
    frame_start();
    for (int i = 0; i < 4; i++) send_bit((i == 0) || (i == 3), 1'b1);
    RESET = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    SER_FRAME_N = 1'b1;
    SER_CLK = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
    repeat (4) tick();
    chk_status("after_reset", IDLE, 0, 0);
    send_frame(16'h005A, 8);
    chk_status("post_reset_load", READY, 1, 0);

    repeat (5) tick();
    chk("load_queue_left", load_q.size(), 0);
    chk("run_queue_left", run_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
